mem_switcher: RTL and testbench
===============================

# mem_switcher

Single-port memory sequencer sharing one external memory bus between the instruction fetch unit and the decoder's data accesses (ldd/ldo/std/sto). It latches the address/data presented on the decoder's `ram_read`/`ram_write` cycle, runs a req/ack transaction on the bus, and returns `mem_busy`/`mem_ready` to the decoder so the PC stalls correctly. Sits between core (decoder, ALU address path, fetch) and the RAM/peripheral bus.

## Interface
- `ADDR_W`, 16, bus address width
- `DATA_W`, 16, bus data width
- `TIMEOUT`, 255, max cycles waiting for `m_ack` before abort (1..255)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `d_read`  in  1  decoder `ram_read`, data read request
- `d_write`  in  1  decoder `ram_write`, data write request
- `d_addr`  in  ADDR_W  data address (ALU output)
- `d_wdata`  in  DATA_W  write data (register file right port)
- `d_rdata`  out  DATA_W  read data, valid while `mem_ready`
- `mem_busy`  out  1  transaction in flight, decoder must hold
- `mem_ready`  out  1  one-cycle read completion pulse
- `f_req`  in  1  fetch request (level)
- `f_addr`  in  ADDR_W  fetch address (PC)
- `f_data`  out  DATA_W  fetched instruction, valid while `f_valid`
- `f_valid`  out  1  one-cycle fetch completion pulse
- `m_req`  out  1  bus request
- `m_we`  out  1  bus write enable
- `m_addr`  out  ADDR_W  bus address
- `m_wdata`  out  DATA_W  bus write data
- `m_rdata`  in  DATA_W  bus read data, sampled with `m_ack`
- `m_ack`  in  1  bus completion
- `bus_err`  out  1  sticky timeout flag, cleared only by reset

## Operation
- States: IDLE, FETCH, DRD, DWR, RDONE.
- IDLE: `d_read` → DRD; else `d_write` → DWR; else `f_req` → FETCH. Data has priority over fetch; simultaneous `d_read`+`d_write` treated as read.
- Requests sampled only in IDLE; ignored in all other states.
- On acceptance: `m_addr`, `m_wdata`, `m_we` registered from requester and held constant until ack; `m_req`=1.
- DRD + `m_ack`: `d_rdata`←`m_rdata`, → RDONE. RDONE lasts exactly one cycle (`mem_ready`=1, `mem_busy`=0), → IDLE.
- DWR + `m_ack`: → IDLE; no `mem_ready` pulse (decoder already advanced PC).
- FETCH + `m_ack`: `f_data`←`m_rdata`, `f_valid`=1 next cycle, → IDLE.
- `mem_busy`=1 in FETCH, DRD, DWR; 0 in IDLE, RDONE.
- Timeout: 8-bit counter cleared on entering a bus state, increments each cycle without ack; at count==TIMEOUT: abort (`m_req`→0), set `bus_err`, complete as if acked with `m_rdata` replaced by all-ones.
- `m_ack` outside a bus state ignored.

## Timing
- Reset (async, immediate): state IDLE, `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `d_rdata`=0, `f_data`=0, `mem_busy`=0, `mem_ready`=0, `f_valid`=0, `bus_err`=0, counter 0. Reset mid-transaction abandons it; no completion pulse.
- All outputs registered.
- Request in cycle T → `m_req`=1, `mem_busy`=1 from T+1.
- `m_ack` in cycle A (A≥T+1) → `m_req`=0, `mem_busy`=0 at A+1; `mem_ready` or `f_valid` high exactly A+1.
- Zero-wait bus (ack in T+1): read round trip 2 cycles; back-to-back accepts possible at A+1 (IDLE) for writes/fetches, A+2 for reads (RDONE).
- Timeout completion at T+1+TIMEOUT.

## Structure
- Package `pcpu_mem_pkg`: state enum `msw_state_t`, `MSW_TO_W`=8, default TIMEOUT constant, all-ones error-data constant.
- One sub-module: `bus_watchdog` (counter, clear/enable inputs, `expired` output).
- Rest single always_ff FSM plus registered output block.

## Test plan
- Read, zero wait: `d_read`, `d_addr`=0x0040, ack T+1 with 0xBEEF → `mem_busy` T+1, `mem_ready`+`d_rdata`=0xBEEF at T+2, single pulse.
- Write, 3 wait states: `d_write`, addr 0x0102, data 0x1234 → `m_we`=1, addr/data stable 4 cycles, no `mem_ready`, `mem_busy` low cycle after ack.
- Contention: `d_read` and `f_req` same cycle → data read first; fetch starts cycle after RDONE; `f_valid` once.
- Timeout: TIMEOUT=4, no ack → abort at T+5, `mem_ready` with `d_rdata`=0xFFFF, `bus_err`=1 sticky.
- Reset mid-read: `rst_n` low during DRD → `m_req`, `mem_busy` 0 immediately; later ack ignored, no `mem_ready`.
- Fetch stream: `f_req` held, ack every cycle → `f_valid` every 2nd cycle, `f_data` matches addresses 0..7.

Source files
------------

// File: rtl/pcpu_mem_pkg.sv
// Shared types and constants for the memory sequencer that arbitrates the
// external memory bus between instruction fetch and decoder data accesses.
package pcpu_mem_pkg;

  // Width of the bus timeout counter
  localparam int MSW_TO_W = 8;

  // Default number of cycles to wait for m_ack before aborting
  localparam int MSW_TIMEOUT_DEF = 255;

  // Read data returned when a transaction is aborted by the watchdog;
  // users slice off the low DATA_W bits
  localparam logic [63:0] MSW_ERR_DATA = '1;

  typedef enum logic [2:0] {
    MSW_IDLE  = 3'd0,
    MSW_FETCH = 3'd1,
    MSW_DRD   = 3'd2,
    MSW_DWR   = 3'd3,
    MSW_RDONE = 3'd4
  } msw_state_t;

  // True in the states that own the bus and wait for m_ack
  function automatic logic msw_is_bus(input msw_state_t s);
    return (s == MSW_FETCH) || (s == MSW_DRD) || (s == MSW_DWR);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a bus transaction which has waited too long for
// its acknowledge. Cleared whenever the sequencer is not on the bus.
module bus_watchdog
  import pcpu_mem_pkg::*;
#(
  parameter int TIMEOUT = MSW_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // The count equals the number of completed wait cycles; the abort fires in
  // the cycle whose increment would bring it to TIMEOUT, so the sequencer is
  // back out of the bus state exactly TIMEOUT cycles after it entered.
  localparam logic [MSW_TO_W-1:0] LAST_CNT = MSW_TO_W'(TIMEOUT - 1);

  logic [MSW_TO_W-1:0] cnt_q;
  logic [MSW_TO_W-1:0] cnt_d;

  // Next count: clear has priority, otherwise count enabled wait cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_switcher.sv
// Single-port memory sequencer. Shares one external req/ack bus between the
// fetch unit and the decoder's load/store accesses. Data requests win over
// fetch; a simultaneous read and write is handled as a read. The decoder
// holds while mem_busy is high; reads finish with a one-cycle mem_ready,
// fetches with a one-cycle f_valid.
//
// Bus handshake: m_req rises the cycle after a request is accepted and stays
// high, with m_addr/m_wdata/m_we constant, up to and including the cycle in
// which m_ack is seen high; m_req drops on the following cycle. An m_ack
// outside a bus cycle is ignored. If no ack arrives within TIMEOUT cycles the
// transaction is aborted, bus_err latches high until reset, and the requester
// is completed with all-ones data.
module mem_switcher
  import pcpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = MSW_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // decoder data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_busy,
  output logic              mem_ready,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_data,
  output logic              f_valid,
  // external memory bus
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // status
  output logic              bus_err,
  output logic [2:0]        dbg_state
);

  localparam logic [DATA_W-1:0] ERR_DATA = MSW_ERR_DATA[DATA_W-1:0];

  msw_state_t        state_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] f_data_q;
  logic              mem_busy_q;
  logic              mem_ready_q;
  logic              f_valid_q;
  logic              bus_err_q;

  logic              in_bus;
  logic              wd_expired;
  logic              done;
  logic [DATA_W-1:0] rd_val;

  assign in_bus = msw_is_bus(state_q);
  // An ack always wins over an abort in the same cycle
  assign done   = in_bus && (m_ack || wd_expired);
  assign rd_val = m_ack ? m_rdata : ERR_DATA;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_bus),
    .en      (in_bus && !m_ack),
    .expired (wd_expired)
  );

  // Sequencer FSM with all bus, data and status outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MSW_IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      d_rdata_q   <= '0;
      f_data_q    <= '0;
      mem_busy_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      f_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      // completion pulses last a single cycle
      mem_ready_q <= 1'b0;
      f_valid_q   <= 1'b0;

      case (state_q)
        MSW_IDLE: begin
          if (d_read) begin
            state_q    <= MSW_DRD;
            m_req_q    <= 1'b1;
            m_we_q     <= 1'b0;
            m_addr_q   <= d_addr;
            mem_busy_q <= 1'b1;
          end else if (d_write) begin
            state_q    <= MSW_DWR;
            m_req_q    <= 1'b1;
            m_we_q     <= 1'b1;
            m_addr_q   <= d_addr;
            m_wdata_q  <= d_wdata;
            mem_busy_q <= 1'b1;
          end else if (f_req) begin
            state_q    <= MSW_FETCH;
            m_req_q    <= 1'b1;
            m_we_q     <= 1'b0;
            m_addr_q   <= f_addr;
            mem_busy_q <= 1'b1;
          end
        end

        MSW_FETCH, MSW_DRD, MSW_DWR: begin
          if (done) begin
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            mem_busy_q <= 1'b0;
            if (!m_ack) begin
              bus_err_q <= 1'b1;
            end
            if (state_q == MSW_DRD) begin
              d_rdata_q   <= rd_val;
              mem_ready_q <= 1'b1;
              state_q     <= MSW_RDONE;
            end else if (state_q == MSW_FETCH) begin
              f_data_q  <= rd_val;
              f_valid_q <= 1'b1;
              state_q   <= MSW_IDLE;
            end else begin
              // writes complete silently; the decoder already moved on
              state_q <= MSW_IDLE;
            end
          end
        end

        MSW_RDONE: begin
          state_q <= MSW_IDLE;
        end

        default: begin
          state_q    <= MSW_IDLE;
          m_req_q    <= 1'b0;
          m_we_q     <= 1'b0;
          mem_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign d_rdata   = d_rdata_q;
  assign f_data    = f_data_q;
  assign mem_busy  = mem_busy_q;
  assign mem_ready = mem_ready_q;
  assign f_valid   = f_valid_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_switcher.sv
// Bench for mem_switcher: directed bus scenarios with a scoreboard of
// expected read/fetch data checked whenever a completion pulse appears.
module tb_mem_switcher;
  import pcpu_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_read, d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_busy, mem_ready;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic          f_valid;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_ack;
  logic          bus_err;
  logic [2:0]    dbg_state;

  // bus responder: manual ack, or auto mode acking every request at once
  // with data derived from the address presented on the bus
  logic          auto_ack;
  logic          man_ack;
  logic [DW-1:0] man_rdata;
  assign m_ack   = auto_ack ? m_req : man_ack;
  assign m_rdata = auto_ack ? (m_addr ^ 16'hA500) : man_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;
  int rd_pulses = 0;
  int fv_pulses = 0;

  logic [DW-1:0] rd_exp_q[$];
  logic [DW-1:0] f_exp_q[$];

  mem_switcher #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .mem_busy  (mem_busy),
    .mem_ready (mem_ready),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_data    (f_data),
    .f_valid   (f_valid),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .bus_err   (bus_err),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n_cyc);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #2;
    n_cyc++;
  endtask

  // scoreboard: compare completion data on the falling edge
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      rd_pulses++;
      if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("d_rdata", d_rdata, rd_exp_q.pop_front());
    end
    if (f_valid === 1'b1) begin
      fv_pulses++;
      if (f_exp_q.size() == 0) check("fv_unexpected", 1, 0);
      else check("f_data", f_data, f_exp_q.pop_front());
    end
  end

  initial begin
    int got;
    int last;
    logic [AW-1:0] pc;

    rst_n = 1'b0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    f_req = 0; f_addr = '0;
    auto_ack = 0; man_ack = 0; man_rdata = '0;

    // reset state
    repeat (3) cycle();
    check("rst_m_req", m_req, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_f_data", f_data, 0);
    check("rst_busy", mem_busy, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_f_valid", f_valid, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_state", dbg_state, MSW_IDLE);
    rst_n = 1'b1;
    repeat (2) cycle();

    // read, zero wait
    d_read = 1; d_addr = 16'h0040;
    rd_exp_q.push_back(16'hBEEF);
    cycle();
    d_read = 0;
    check("rd0_busy", mem_busy, 1);
    check("rd0_m_req", m_req, 1);
    check("rd0_m_we", m_we, 0);
    check("rd0_m_addr", m_addr, 16'h0040);
    check("rd0_ready_early", mem_ready, 0);
    man_ack = 1; man_rdata = 16'hBEEF;
    cycle();
    man_ack = 0;
    check("rd0_ready", mem_ready, 1);
    check("rd0_busy_low", mem_busy, 0);
    check("rd0_m_req_low", m_req, 0);
    check("rd0_state_rdone", dbg_state, MSW_RDONE);
    cycle();
    check("rd0_ready_single", mem_ready, 0);
    check("rd0_state_idle", dbg_state, MSW_IDLE);

    // write, three wait states (ack lands on the last cycle before abort)
    d_write = 1; d_addr = 16'h0102; d_wdata = 16'h1234;
    cycle();
    d_write = 0; d_addr = 16'hFFFF; d_wdata = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      check("wr_m_req", m_req, 1);
      check("wr_m_we", m_we, 1);
      check("wr_m_addr", m_addr, 16'h0102);
      check("wr_m_wdata", m_wdata, 16'h1234);
      check("wr_busy", mem_busy, 1);
      check("wr_ready", mem_ready, 0);
      if (k == 3) man_ack = 1;
      cycle();
    end
    man_ack = 0;
    check("wr_busy_low", mem_busy, 0);
    check("wr_m_req_low", m_req, 0);
    check("wr_ready_none", mem_ready, 0);
    check("wr_no_err", bus_err, 0);
    check("wr_state_idle", dbg_state, MSW_IDLE);
    cycle();

    // contention: data read wins over fetch
    d_read = 1; d_addr = 16'h0200; f_req = 1; f_addr = 16'h0300;
    rd_exp_q.push_back(16'h5555);
    f_exp_q.push_back(16'h6666);
    cycle();
    d_read = 0;
    check("ct_state_drd", dbg_state, MSW_DRD);
    check("ct_m_addr_rd", m_addr, 16'h0200);
    check("ct_m_we", m_we, 0);
    man_ack = 1; man_rdata = 16'h5555;
    cycle();
    man_ack = 0;
    check("ct_ready", mem_ready, 1);
    check("ct_m_req_low", m_req, 0);
    check("ct_no_fv", f_valid, 0);
    cycle();
    check("ct_state_idle", dbg_state, MSW_IDLE);
    check("ct_m_req_idle", m_req, 0);
    cycle();
    f_req = 0;
    check("ct_state_fetch", dbg_state, MSW_FETCH);
    check("ct_m_req_f", m_req, 1);
    check("ct_m_addr_f", m_addr, 16'h0300);
    man_ack = 1; man_rdata = 16'h6666;
    cycle();
    man_ack = 0;
    check("ct_fv", f_valid, 1);
    check("ct_ready_none", mem_ready, 0);
    cycle();
    check("ct_fv_single", f_valid, 0);

    // timeout: no ack, abort after TO cycles on the bus
    d_read = 1; d_addr = 16'h0444;
    rd_exp_q.push_back(16'hFFFF);
    cycle();
    d_read = 0;
    for (int k = 0; k < TO; k++) begin
      check("to_m_req", m_req, 1);
      check("to_err_low", bus_err, 0);
      check("to_ready_low", mem_ready, 0);
      cycle();
    end
    check("to_ready", mem_ready, 1);
    check("to_m_req_low", m_req, 0);
    check("to_busy_low", mem_busy, 0);
    check("to_err", bus_err, 1);
    cycle();
    check("to_ready_single", mem_ready, 0);
    check("to_err_sticky", bus_err, 1);
    // a later good write keeps the flag set
    d_write = 1; d_addr = 16'h0010; d_wdata = 16'h00AA;
    cycle();
    d_write = 0;
    man_ack = 1;
    cycle();
    man_ack = 0;
    check("to_err_sticky2", bus_err, 1);
    cycle();

    // reset in the middle of a read
    d_read = 1; d_addr = 16'h0555;
    cycle();
    d_read = 0;
    check("rr_m_req", m_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_m_req_low", m_req, 0);
    check("rr_busy_low", mem_busy, 0);
    check("rr_err_clr", bus_err, 0);
    check("rr_state", dbg_state, MSW_IDLE);
    man_ack = 1; man_rdata = 16'h7777;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("rr_ready_none", mem_ready, 0);
    check("rr_m_req_none", m_req, 0);
    man_ack = 0;
    cycle();
    check("rr_idle", dbg_state, MSW_IDLE);

    // fetch stream, zero-wait bus
    auto_ack = 1;
    pc = '0;
    f_addr = pc; f_req = 1;
    f_exp_q.push_back(pc ^ 16'hA500);
    got = 0;
    last = -1;
    for (int k = 0; k < 40 && got < 8; k++) begin
      cycle();
      if (f_valid === 1'b1) begin
        got++;
        if (last >= 0) check("fs_gap", n_cyc - last, 2);
        last = n_cyc;
        if (got < 8) begin
          pc = pc + 1'b1;
          f_addr = pc;
          f_exp_q.push_back(pc ^ 16'hA500);
        end else begin
          f_req = 0;
        end
      end
    end
    check("fs_count", got, 8);
    repeat (3) cycle();
    auto_ack = 0;
    check("fs_idle", dbg_state, MSW_IDLE);
    check("fs_m_req_low", m_req, 0);

    // scoreboard drained, pulse totals
    check("rd_q_empty", rd_exp_q.size(), 0);
    check("f_q_empty", f_exp_q.size(), 0);
    check("rd_pulses", rd_pulses, 3);
    check("fv_pulses", fv_pulses, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
